bcd_scan_counter: RTL and testbench

Parametrised N-digit cascaded BCD counter with built-in seven-segment scan driver. It is the generalised successor to the fixed two-digit stopwatch datapath: it takes a divided count tick and counts up or down with load, clear, and wrap-or-saturate limits. It also time-multiplexes all digits onto one active-low cathode bus. The block sits between the clock dividers and the board display pins.

---
 rtl/bcd_scan_counter.sv | 186 ++++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_counter
//  Description : N-digit cascaded BCD up/down counter with clear, load and
//                wrap-or-saturate limits, plus a time-multiplexed seven-
//                segment scan driver (active-low anodes and cathodes).
//                Optional feature macro: BCD_SCAN_LEADING_BLANK_EN
//                (blanks digits above the most significant non-zero digit).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_counter #(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 10000,
    parameter int WRAP     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  terminal,
    output logic [DIGITS-1:0]     anodes,
    output logic [6:0]            cathodes
);

    localparam int                     c_IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                     c_SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [c_SCAN_W-1:0]    c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]     c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic [6:0]             c_BLANK     = 7'b1111111;

    logic [4*DIGITS-1:0] r_count;
    logic                r_terminal;
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [c_IDX_W-1:0]  r_digit_idx;
    logic [DIGITS-1:0]   r_anodes;
    logic [6:0]          r_cathodes;

    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic                w_carry_up;
    logic                w_carry_dn;
    logic [4*DIGITS-1:0] w_load_clamped;
    logic [3:0]          w_sel_digit;
    logic [DIGITS-1:0]   w_anodes_next;
    logic                w_blank;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = c_BLANK;
        endcase
    endfunction

    // Preset nibbles above 9 are forced to 9 so the counter never holds non-BCD
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_clamp
            assign w_load_clamped[4*i +: 4] =
                (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
        end
    endgenerate

    // Ripple the +1 / -1 carry through the digits; a carry out of the top marks a limit
    always_comb begin
        w_inc      = r_count;
        w_dec      = r_count;
        w_carry_up = 1'b1;
        w_carry_dn = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry_up) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry_up      = 1'b0;
                end
            end
            if (w_carry_dn) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_carry_dn      = 1'b0;
                end
            end
        end
    end

    // Counter update: clear > load > qualified tick > hold; terminal flags limit hits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_terminal <= 1'b0;
        end else begin
            r_terminal <= 1'b0;
            if (clear) begin
                r_count <= '0;
            end else if (load) begin
                r_count <= w_load_clamped;
            end else if (tick && enable) begin
                if (up) begin
                    r_terminal <= w_carry_up;
                    if (!(w_carry_up && (WRAP == 0))) begin
                        r_count <= w_inc;
                    end
                end else begin
                    r_terminal <= w_carry_dn;
                    if (!(w_carry_dn && (WRAP == 0))) begin
                        r_count <= w_dec;
                    end
                end
            end
        end
    end

    // Dwell counter and digit index; runs continuously regardless of enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (r_scan_cnt == c_SCAN_LAST) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == c_IDX_LAST) ? '0 : r_digit_idx + c_IDX_W'(1);
        end else begin
            r_scan_cnt  <= r_scan_cnt + c_SCAN_W'(1);
        end
    end

    // Pick the nibble and the anode for the digit currently being scanned
    always_comb begin
        w_sel_digit   = 4'd0;
        w_anodes_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit_idx == c_IDX_W'(i)) begin
                w_sel_digit      = r_count[4*i +: 4];
                w_anodes_next[i] = 1'b0;
            end
        end
    end

`ifdef BCD_SCAN_LEADING_BLANK_EN
    // Blank a non-ones digit when it and every digit above it are zero
    always_comb begin
        w_blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if ((r_digit_idx == c_IDX_W'(i)) && ((r_count >> (4*i)) == '0)) begin
                w_blank = 1'b1;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    // Anodes and cathodes registered together so they never tear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_anodes   <= '1;
            r_cathodes <= c_BLANK;
        end else begin
            r_anodes   <= w_anodes_next;
            r_cathodes <= w_blank ? c_BLANK : seg_decode(w_sel_digit);
        end
    end

    assign count    = r_count;
    assign terminal = r_terminal;
    assign anodes   = r_anodes;
    assign cathodes = r_cathodes;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_scan_counter
//  Description : Self-checking bench for bcd_scan_counter. Three instances
//                (2-digit wrap, 2-digit saturate, 3-digit wrap, SCAN_DIV=4)
//                share one stimulus stream and are compared against an
//                integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_counter;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        enable;
    logic        up;
    logic        clear;
    logic        load;
    logic [11:0] load_value;

    logic [7:0]  count_w,  count_s;
    logic [11:0] count_3;
    logic        term_w, term_s, term_3;
    logic [1:0]  an_w, an_s;
    logic [2:0]  an_3;
    logic [6:0]  cath_w, cath_s, cath_3;

    bcd_scan_counter #(.DIGITS(2), .SCAN_DIV(4), .WRAP(1)) u_dut_w (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .up(up),
        .clear(clear), .load(load), .load_value(load_value[7:0]),
        .count(count_w), .terminal(term_w), .anodes(an_w), .cathodes(cath_w));

    bcd_scan_counter #(.DIGITS(2), .SCAN_DIV(4), .WRAP(0)) u_dut_s (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .up(up),
        .clear(clear), .load(load), .load_value(load_value[7:0]),
        .count(count_s), .terminal(term_s), .anodes(an_s), .cathodes(cath_s));

    bcd_scan_counter #(.DIGITS(3), .SCAN_DIV(4), .WRAP(1)) u_dut_3 (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .up(up),
        .clear(clear), .load(load), .load_value(load_value),
        .count(count_3), .terminal(term_3), .anodes(an_3), .cathodes(cath_3));

    logic [11:0] obs_cnt  [3];
    logic        obs_term [3];
    assign obs_cnt[0]  = {4'h0, count_w};
    assign obs_cnt[1]  = {4'h0, count_s};
    assign obs_cnt[2]  = count_3;
    assign obs_term[0] = term_w;
    assign obs_term[1] = term_s;
    assign obs_term[2] = term_3;

    int n_dig  [3] = '{2, 2, 3};
    int n_wrap [3] = '{1, 0, 1};
    int m_val  [3];
    int m_prev [3];
    bit m_term [3];
    int edges;
    int errors;
    int checks;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int clamp_val(input logic [11:0] lv, input int d);
        int v = 0;
        int n;
        for (int i = d - 1; i >= 0; i--) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 9;
            v = v * 10 + n;
        end
        return v;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        for (int i = 0; i < 3; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected cathodes when digit idx of value val is on display
    function automatic logic [6:0] exp_cath(input int val, input int idx);
`ifdef BCD_SCAN_LEADING_BLANK_EN
        if (idx > 0 && val < pow10(idx)) return 7'b1111111;
`endif
        return seg((val / pow10(idx)) % 10);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_val[k]  = 0;
            m_prev[k] = 0;
            m_term[k] = 1'b0;
        end
        edges = 0;
    endtask

    // Advance one clock edge, stepping the reference model with the applied inputs
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            int lim;
            lim       = pow10(n_dig[k]) - 1;
            m_prev[k] = m_val[k];
            m_term[k] = 1'b0;
            if (clear) begin
                m_val[k] = 0;
            end else if (load) begin
                m_val[k] = clamp_val(load_value, n_dig[k]);
            end else if (tick && enable) begin
                if (up) begin
                    if (m_val[k] == lim) begin
                        m_term[k] = 1'b1;
                        m_val[k]  = (n_wrap[k] != 0) ? 0 : lim;
                    end else begin
                        m_val[k] = m_val[k] + 1;
                    end
                end else begin
                    if (m_val[k] == 0) begin
                        m_term[k] = 1'b1;
                        m_val[k]  = (n_wrap[k] != 0) ? lim : 0;
                    end else begin
                        m_val[k] = m_val[k] - 1;
                    end
                end
            end
        end
        edges++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick = 1'b0; enable = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++; if (count_w !== 8'h00) begin errors++; $display("FAIL reset_count_w: got %h expected 00", count_w); end
        checks++; if (count_s !== 8'h00) begin errors++; $display("FAIL reset_count_s: got %h expected 00", count_s); end
        checks++; if (count_3 !== 12'h000) begin errors++; $display("FAIL reset_count_3: got %h expected 000", count_3); end
        checks++; if (term_w !== 1'b0) begin errors++; $display("FAIL reset_term_w: got %b expected 0", term_w); end
        checks++; if (an_w !== 2'b11) begin errors++; $display("FAIL reset_anodes_w: got %b expected 11", an_w); end
        checks++; if (an_3 !== 3'b111) begin errors++; $display("FAIL reset_anodes_3: got %b expected 111", an_3); end
        checks++; if (cath_w !== 7'b1111111) begin errors++; $display("FAIL reset_cath_w: got %b expected 1111111", cath_w); end
        checks++; if (cath_3 !== 7'b1111111) begin errors++; $display("FAIL reset_cath_3: got %b expected 1111111", cath_3); end
        @(negedge clk);
        reset = 1'b1;
        cycle();
        checks++; if (an_w !== 2'b10) begin errors++; $display("FAIL first_anodes_w: got %b expected 10", an_w); end
        checks++; if (cath_w !== 7'b1000000) begin errors++; $display("FAIL first_cath_w: got %b expected 1000000", cath_w); end
    endtask

    task automatic test_wrap_up();
        int pulses = 0;
        up = 1'b1; tick = 1'b1; enable = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            cycle();
            pulses += int'(term_w);
            if (n == 99) begin
                checks++; if (count_w !== 8'h99) begin errors++; $display("FAIL wrap_reach_99: got %h expected 99", count_w); end
                checks++; if (term_w !== 1'b0) begin errors++; $display("FAIL wrap_term_early: got %b expected 0", term_w); end
            end
        end
        checks++; if (count_w !== 8'h00) begin errors++; $display("FAIL wrap_to_00: got %h expected 00", count_w); end
        checks++; if (term_w !== 1'b1) begin errors++; $display("FAIL wrap_term: got %b expected 1", term_w); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL wrap_pulse_count: got %0d expected 1", pulses); end
        tick = 1'b0;
    endtask

    task automatic test_saturate_down();
        int pulses = 0;
        clear = 1'b1;
        cycle();
        clear = 1'b0; up = 1'b0; tick = 1'b1; enable = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            pulses += int'(term_s);
            checks++; if (count_s !== 8'h00) begin errors++; $display("FAIL sat_hold_00: got %h expected 00", count_s); end
            checks++; if (term_s !== 1'b1) begin errors++; $display("FAIL sat_term: got %b expected 1", term_s); end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL sat_pulse_count: got %0d expected 3", pulses); end
        tick = 1'b0; load = 1'b1; load_value = 12'h01F;
        cycle();
        load = 1'b0;
        checks++; if (count_s !== 8'h19) begin errors++; $display("FAIL load_clamp: got %h expected 19", count_s); end
        checks++; if (term_s !== 1'b0) begin errors++; $display("FAIL load_no_term: got %b expected 0", term_s); end
    endtask

    task automatic test_three_digit();
        load = 1'b1; load_value = 12'h100;
        cycle();
        load = 1'b0; tick = 1'b1; enable = 1'b1; up = 1'b0;
        cycle();
        checks++; if (count_3 !== 12'h099) begin errors++; $display("FAIL borrow_099: got %h expected 099", count_3); end
        up = 1'b1;
        cycle();
        checks++; if (count_3 !== 12'h100) begin errors++; $display("FAIL carry_100: got %h expected 100", count_3); end
        checks++; if (term_3 !== 1'b0) begin errors++; $display("FAIL carry_no_term: got %b expected 0", term_3); end
        tick = 1'b0;
    endtask

    task automatic test_priority();
        // Saturated 2-digit instance at 99 so a tick alone would fire terminal
        load = 1'b1; load_value = 12'h999;
        cycle();
        clear = 1'b1; load = 1'b1; load_value = 12'h042; tick = 1'b1; enable = 1'b1; up = 1'b1;
        cycle();
        clear = 1'b0; load = 1'b0; tick = 1'b0;
        checks++; if (count_w !== 8'h00) begin errors++; $display("FAIL prio_count_w: got %h expected 00", count_w); end
        checks++; if (count_s !== 8'h00) begin errors++; $display("FAIL prio_count_s: got %h expected 00", count_s); end
        checks++; if (count_3 !== 12'h000) begin errors++; $display("FAIL prio_count_3: got %h expected 000", count_3); end
        checks++; if (term_s !== 1'b0) begin errors++; $display("FAIL prio_term_s: got %b expected 0", term_s); end
        checks++; if (term_3 !== 1'b0) begin errors++; $display("FAIL prio_term_3: got %b expected 0", term_3); end
        load = 1'b1; load_value = 12'h035;
        cycle();
        load = 1'b0; tick = 1'b1; enable = 1'b0;
        cycle();
        tick = 1'b0;
        checks++; if (count_w !== 8'h35) begin errors++; $display("FAIL disabled_tick_w: got %h expected 35", count_w); end
        checks++; if (count_3 !== 12'h035) begin errors++; $display("FAIL disabled_tick_3: got %h expected 035", count_3); end
    endtask

    task automatic test_display();
        logic [1:0] ea_w;
        logic [2:0] ea_3;
        int         iw, i3;
        load = 1'b1; load_value = 12'h007;
        cycle();
        load = 1'b0;
        for (int n = 0; n < 16; n++) begin
            cycle();
            iw = ((edges - 1) / 4) % 2;
            i3 = ((edges - 1) / 4) % 3;
            ea_w = 2'b11;  ea_w[iw] = 1'b0;
            ea_3 = 3'b111; ea_3[i3] = 1'b0;
            checks++; if (an_w !== ea_w) begin errors++; $display("FAIL disp_anodes_w: got %b expected %b", an_w, ea_w); end
            checks++; if (cath_w !== exp_cath(m_prev[0], iw)) begin errors++; $display("FAIL disp_cath_w: got %b expected %b", cath_w, exp_cath(m_prev[0], iw)); end
            checks++; if (an_3 !== ea_3) begin errors++; $display("FAIL disp_anodes_3: got %b expected %b", an_3, ea_3); end
            checks++; if (cath_3 !== exp_cath(m_prev[2], i3)) begin errors++; $display("FAIL disp_cath_3: got %b expected %b", cath_3, exp_cath(m_prev[2], i3)); end
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_value = 12'h057;
        cycle();
        load = 1'b0;
        cycle();
        cycle();
        #2 reset = 1'b0;
        #1;
        checks++; if (count_w !== 8'h00) begin errors++; $display("FAIL async_count_w: got %h expected 00", count_w); end
        checks++; if (count_3 !== 12'h000) begin errors++; $display("FAIL async_count_3: got %h expected 000", count_3); end
        checks++; if (an_w !== 2'b11) begin errors++; $display("FAIL async_anodes_w: got %b expected 11", an_w); end
        checks++; if (cath_w !== 7'b1111111) begin errors++; $display("FAIL async_cath_w: got %b expected 1111111", cath_w); end
        checks++; if (term_w !== 1'b0) begin errors++; $display("FAIL async_term_w: got %b expected 0", term_w); end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0] ea_w;
        int         iw;
        for (int n = 0; n < 400; n++) begin
            clear      = ($urandom % 20) == 0;
            load       = ($urandom % 12) == 0;
            load_value = 12'($urandom);
            tick       = ($urandom % 3) != 0;
            enable     = ($urandom % 5) != 0;
            if (($urandom % 16) == 0) up = ~up;
            cycle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_cnt[k] !== to_bcd(m_val[k])) begin
                    errors++;
                    $display("FAIL rand_count[%0d]: got %h expected %h", k, obs_cnt[k], to_bcd(m_val[k]));
                end
                checks++;
                if (obs_term[k] !== m_term[k]) begin
                    errors++;
                    $display("FAIL rand_term[%0d]: got %b expected %b", k, obs_term[k], m_term[k]);
                end
            end
            iw = ((edges - 1) / 4) % 2;
            ea_w = 2'b11; ea_w[iw] = 1'b0;
            checks++; if (an_w !== ea_w) begin errors++; $display("FAIL rand_anodes_w: got %b expected %b", an_w, ea_w); end
            checks++; if (cath_w !== exp_cath(m_prev[0], iw)) begin errors++; $display("FAIL rand_cath_w: got %b expected %b", cath_w, exp_cath(m_prev[0], iw)); end
        end
        clear = 1'b0; load = 1'b0; tick = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_three_digit();
        test_priority();
        test_display();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
